// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester, receive and byte-engine signals of the
// SPI arbiter, bundled with arbiter (slave) and environment (master) views.
interface spi_arbiter_if;
  logic       r0_req;
  logic       r0_last;
  logic [7:0] r0_tx;
  logic       r0_ack;
  logic       r1_req;
  logic       r1_last;
  logic [7:0] r1_tx;
  logic       r1_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_owner;
  logic       eng_start;
  logic [7:0] eng_tx;
  logic       eng_done;
  logic [7:0] eng_rx;
  logic       ss_n;

  modport slave (
    input  r0_req, r0_last, r0_tx,
    input  r1_req, r1_last, r1_tx,
    input  eng_done, eng_rx,
    output r0_ack, r1_ack,
    output rx_data, rx_valid, rx_owner,
    output eng_start, eng_tx, ss_n
  );

  modport master (
    output r0_req, r0_last, r0_tx,
    output r1_req, r1_last, r1_tx,
    output eng_done, eng_rx,
    input  r0_ack, r1_ack,
    input  rx_data, rx_valid, rx_owner,
    input  eng_start, eng_tx, ss_n
  );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin share of one SPI byte engine between two
// requesters, with registered ss_n setup/hold/gap framing.
module spi_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_arbiter_if.slave bus
);
  localparam int M1 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int MX = (M1 > GAP) ? M1 : GAP;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_WAIT,
    S_HOLD,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          lown_q, lown_d;
  logic          last_q, last_d;
  logic          ss_n_q, ss_n_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rxd_q, rxd_d;
  logic          rxv_q, rxv_d;
  logic          rxo_q, rxo_d;

  logic       own_req;
  logic       own_last;
  logic [7:0] own_tx;

  assign own_req  = owner_q ? bus.r1_req  : bus.r0_req;
  assign own_last = owner_q ? bus.r1_last : bus.r0_last;
  assign own_tx   = owner_q ? bus.r1_tx   : bus.r0_tx;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lown_d  = lown_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          // contention goes to whoever was not served last
          if (bus.r0_req && bus.r1_req) owner_d = ~lown_q;
          else                          owner_d = bus.r1_req;
          lown_d  = owner_d;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_END) state_d = S_XFER;
      end
      S_XFER: begin
        last_d  = own_last;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.eng_done) begin
          if (last_q || !own_req) state_d = S_HOLD;
          else                    state_d = S_XFER;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_END) state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == GAP_END) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == S_SETUP ||
         state_q == S_HOLD  ||
         state_q == S_GAP))
      cnt_d = cnt_q + 1'b1;
    tx_d   = (state_d == S_XFER) ? own_tx : tx_q;
    rxv_d  = (state_q == S_WAIT) && bus.eng_done;
    rxd_d  = rxv_d ? bus.eng_rx : rxd_q;
    rxo_d  = rxv_d ? owner_q : rxo_q;
    // registered from next state so ss_n never glitches
    ss_n_d = (state_d == S_IDLE) || (state_d == S_GAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      lown_q  <= 1'b1;
      last_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      tx_q    <= 8'h00;
      rxd_q   <= 8'h00;
      rxv_q   <= 1'b0;
      rxo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      lown_q  <= lown_d;
      last_q  <= last_d;
      ss_n_q  <= ss_n_d;
      tx_q    <= tx_d;
      rxd_q   <= rxd_d;
      rxv_q   <= rxv_d;
      rxo_q   <= rxo_d;
    end
  end

  assign bus.eng_start = (state_q == S_XFER);
  assign bus.r0_ack    = (state_q == S_XFER) && !owner_q;
  assign bus.r1_ack    = (state_q == S_XFER) && owner_q;
  assign bus.eng_tx    = tx_q;
  assign bus.rx_data   = rxd_q;
  assign bus.rx_valid  = rxv_q;
  assign bus.rx_owner  = rxo_q;
  assign bus.ss_n      = ss_n_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: randomized requesters and byte engine, with a
// scoreboard monitor checking framing, grant order and data.
module tb_spi_arbiter;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int GAP      = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spi_arbiter_if bus();

  spi_arbiter #(
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .GAP     (GAP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [8:0] rx_exp[$];

  bit         eng_rand = 1'b0;
  int         eng_lat  = 3;
  logic [7:0] eng_fix  = 8'h00;
  bit         spur_tgl = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input logic req,
                       input logic last, input logic [7:0] tx);
    if (id) begin
      bus.r1_req = req; bus.r1_last = last; bus.r1_tx = tx;
    end else begin
      bus.r0_req = req; bus.r0_last = last; bus.r0_tx = tx;
    end
  endtask

  // base != 0 sends base, base+1, ...; otherwise random bytes
  task automatic send_frame(input bit id, input int n,
                            input bit abort, input logic [7:0] base);
    logic [7:0] b;
    int         cnt;
    logic       ack;
    for (int i = 0; i < n; i++) begin
      b = (base != 8'h00) ? base + 8'(i) : 8'($urandom);
      drive(id, 1'b1, (i == n - 1) && !abort, b);
      if (id) exp1.push_back(b);
      else    exp0.push_back(b);
      cnt = 0;
      do begin
        tick();
        cnt++;
        ack = id ? bus.r1_ack : bus.r0_ack;
      end while (!ack && cnt < 400);
      if (!ack) begin
        check("ack_timeout", 32'(cnt), 32'(0));
        drive(id, 1'b0, 1'b0, 8'h00);
        return;
      end
      tick();
    end
    drive(id, 1'b0, 1'b0, 8'h00);
  endtask

  // byte engine model
  initial begin
    logic [7:0] stx;
    logic [7:0] rb;
    logic       own;
    int         lat;
    bit         ok;
    bit         spur_seen;
    spur_seen    = 1'b0;
    bus.eng_done = 1'b0;
    bus.eng_rx   = 8'h00;
    tick();
    forever begin
      if (rst_n && bus.eng_start) begin
        stx = bus.eng_tx;
        own = bus.r1_ack;
        lat = eng_rand ? $urandom_range(1, 5) : eng_lat;
        ok  = 1'b1;
        for (int k = 0; k < lat; k++) begin
          tick();
          if (!rst_n) ok = 1'b0;
        end
        if (ok && rst_n) begin
          check("eng_tx_stable", 32'(bus.eng_tx), 32'(stx));
          rb = (eng_fix != 8'h00) ? eng_fix : 8'($urandom);
          rx_exp.push_back({own, rb});
          bus.eng_done = 1'b1;
          bus.eng_rx   = rb;
          tick();
          bus.eng_done = 1'b0;
        end
      end else if (spur_tgl != spur_seen) begin
        spur_seen    = spur_tgl;
        bus.eng_done = 1'b1;
        bus.eng_rx   = 8'hEE;
        tick();
        bus.eng_done = 1'b0;
      end else begin
        tick();
      end
    end
  end

  // monitor / scoreboard
  int         cyc = 0;
  int         fall_cyc = 0;
  int         rise_cyc = 0;
  int         done_cyc = 0;
  bit         prev_ss = 1'b1;
  bit         have_rise = 1'b0;
  bit         first = 1'b0;
  logic       m_last = 1'b1;
  logic       exp_owner = 1'b0;
  logic       frame_owner = 1'b0;
  logic       own_m;
  logic [1:0] prev_req = 2'b00;
  logic [8:0] e;
  logic [7:0] eb;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_ss   = 1'b1;
      have_rise = 1'b0;
      first     = 1'b0;
      m_last    = 1'b1;
      prev_req  = 2'b00;
    end else begin
      if (prev_ss && !bus.ss_n) begin
        if (have_rise)
          check("gap_len", 32'(cyc - rise_cyc >= GAP + 1), 32'(1));
        exp_owner = (prev_req == 2'b11) ? ~m_last : prev_req[1];
        m_last    = exp_owner;
        fall_cyc  = cyc;
        first     = 1'b1;
      end
      if (!prev_ss && bus.ss_n) begin
        check("hold_len", 32'(cyc - done_cyc), 32'(CS_HOLD + 1));
        rise_cyc  = cyc;
        have_rise = 1'b1;
      end
      if (bus.eng_done && !bus.ss_n) done_cyc = cyc;
      if (bus.eng_start) begin
        check("ss_low_at_start", 32'(bus.ss_n), 32'(0));
        check("one_ack", 32'(bus.r0_ack ^ bus.r1_ack), 32'(1));
        own_m = bus.r1_ack;
        if (first) begin
          check("setup_len", 32'(cyc - fall_cyc), 32'(CS_SETUP));
          check("grant_owner", 32'(own_m), 32'(exp_owner));
          frame_owner = own_m;
          first       = 1'b0;
        end else begin
          check("frame_owner", 32'(own_m), 32'(frame_owner));
        end
        if ((own_m ? exp1.size() : exp0.size()) == 0) begin
          check("tx_unexpected", 32'(bus.eng_start), 32'(0));
        end else begin
          eb = own_m ? exp1.pop_front() : exp0.pop_front();
          check("eng_tx", 32'(bus.eng_tx), 32'(eb));
        end
      end else if (bus.r0_ack || bus.r1_ack) begin
        check("ack_no_start", 32'({bus.r1_ack, bus.r0_ack}), 32'(0));
      end
      if (bus.rx_valid) begin
        if (rx_exp.size() == 0) begin
          check("rx_unexpected", 32'(bus.rx_valid), 32'(0));
        end else begin
          e = rx_exp.pop_front();
          check("rx_data", 32'(bus.rx_data), 32'(e[7:0]));
          check("rx_owner", 32'(bus.rx_owner), 32'(e[8]));
        end
      end
      prev_req = {bus.r1_req, bus.r0_req};
    end
    prev_ss = bus.ss_n;
  end

  initial begin
    int cnt;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    check("rst_ss_n", 32'(bus.ss_n), 32'(1));
    check("rst_eng_start", 32'(bus.eng_start), 32'(0));
    check("rst_r0_ack", 32'(bus.r0_ack), 32'(0));
    check("rst_r1_ack", 32'(bus.r1_ack), 32'(0));
    check("rst_rx_valid", 32'(bus.rx_valid), 32'(0));
    check("rst_rx_data", 32'(bus.rx_data), 32'(0));
    check("rst_rx_owner", 32'(bus.rx_owner), 32'(0));
    check("rst_eng_tx", 32'(bus.eng_tx), 32'(0));
    rst_n = 1'b1;
    repeat (2) tick();

    // single byte, fixed data
    eng_fix = 8'h5A;
    send_frame(1'b0, 1, 1'b0, 8'hAB);
    repeat (12) tick();
    eng_fix = 8'h00;

    // three-byte frame 01,02,03
    send_frame(1'b0, 3, 1'b0, 8'h01);
    repeat (12) tick();

    // simultaneous requests, twice
    repeat (2) begin
      fork
        send_frame(1'b0, 1, 1'b0, 8'h00);
        send_frame(1'b1, 1, 1'b0, 8'h00);
      join
      repeat (12) tick();
    end

    // r1 arrives in the middle of an r0 frame
    fork
      send_frame(1'b0, 3, 1'b0, 8'h00);
      begin
        repeat (6) tick();
        send_frame(1'b1, 2, 1'b0, 8'h00);
      end
    join
    repeat (12) tick();

    // aborted frame
    send_frame(1'b0, 1, 1'b1, 8'h00);
    repeat (10) tick();
    check("abort_ss_high", 32'(bus.ss_n), 32'(1));
    send_frame(1'b1, 1, 1'b0, 8'h00);
    repeat (12) tick();

    // spurious done while idle
    spur_tgl = ~spur_tgl;
    repeat (3) begin
      tick();
      check("spur_rx_valid", 32'(bus.rx_valid), 32'(0));
    end

    // reset while waiting on the engine
    eng_lat = 6;
    fork
      send_frame(1'b0, 1, 1'b0, 8'h00);
      begin
        cnt = 0;
        while (!bus.eng_start && cnt < 50) begin
          tick();
          cnt++;
        end
        check("rst_wait_start", 32'(bus.eng_start), 32'(1));
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_ss_n", 32'(bus.ss_n), 32'(1));
        check("midrst_eng_start", 32'(bus.eng_start), 32'(0));
        repeat (2) tick();
        rst_n = 1'b1;
      end
    join
    repeat (8) begin
      tick();
      check("midrst_no_rx", 32'(bus.rx_valid), 32'(0));
    end
    eng_lat = 3;
    fork
      send_frame(1'b0, 2, 1'b0, 8'h00);
      send_frame(1'b1, 1, 1'b0, 8'h00);
    join
    repeat (12) tick();

    // randomized traffic
    eng_rand = 1'b1;
    for (int it = 0; it < 40; it++) begin
      fork
        if ($urandom_range(0, 3) != 0) begin
          repeat ($urandom_range(0, 6)) tick();
          send_frame(1'b0, $urandom_range(1, 3),
                     $urandom_range(0, 4) == 0, 8'h00);
        end
        if ($urandom_range(0, 3) != 0) begin
          repeat ($urandom_range(0, 6)) tick();
          send_frame(1'b1, $urandom_range(1, 3),
                     $urandom_range(0, 4) == 0, 8'h00);
        end
      join
    end
    repeat (20) tick();
    check("drained",
          32'(exp0.size() + exp1.size() + rx_exp.size()), 32'(0));
    check("end_ss_high", 32'(bus.ss_n), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
